rate_mult_gen: RTL and testbench

Parametrised, registered binary rate multiplier. It is the successor to the single-channel 8-bit fractional-multiplier counter/compare logic. A free-running WIDTH-bit counter is shared by NUM_CH channels. Each channel emits exactly rate[k] output pulses per 2^WIDTH enabled cycles. Rate updates are double-buffered and take effect only at the period wrap, so no period is ever mixed.

---
 rtl/rate_mult_pkg.sv | 30 +++
 rtl/rate_mult_chan.sv | 118 +++++++++++
 rtl/rate_mult_gen.sv | 92 +++++++++
 tb/tb_rate_mult_gen.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rate_mult_pkg.sv
// Shared types, constants and the binary-rate select function for rate_mult_gen.
// The RATE_MULT_PULSE_CNT_EN macro (see rate_mult_chan) enables per-channel pulse counting.
package rate_mult_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] rate_vec_t;

    localparam rate_vec_t CNT_ALL_ONES = {MAX_WIDTH{1'b1}};

    // Pulse when the lowest set bit of c is j and rate bit WIDTH-1-j is set.
    // Counter values with lowest set bit j occur 2^(w-1-j) times per period, so the period total equals r.
    function automatic logic sel_f(input rate_vec_t c, input rate_vec_t r, input int unsigned w);
        logic hit;
        logic found;
        hit   = 1'b0;
        found = 1'b0;
        for (int unsigned j = 0; j < MAX_WIDTH; j++) begin
            if (!found && (j < w) && c[j]) begin
                hit   = r[5'(w - 32'd1 - j)];
                found = 1'b1;
            end else begin
                hit   = hit;
                found = found;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/rate_mult_chan.sv
// One rate channel: double-buffered rate, select and registered pulse.
// Optional accumulator of pulses per period when RATE_MULT_PULSE_CNT_EN is defined.
module rate_mult_chan
    import rate_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             force_i,
    input  logic [WIDTH-1:0] rate_in_i,
    input  logic             rate_ld_i,
    input  logic             rate_pend_i,
    input  logic             wrap_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             pulse_o,
    output logic [WIDTH:0]   pulse_cnt_o
);

    logic [WIDTH-1:0] act_q, act_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pulse_q, pulse_d;
    logic             sel_s;

    assign sel_s = sel_f(rate_vec_t'(cnt_i), rate_vec_t'(act_q), WIDTH);

    // Rate buffering and next pulse; a load coinciding with clr or wrap bypasses the pending buffer.
    always_comb begin
        act_d   = act_q;
        pend_d  = pend_q;
        pulse_d = 1'b0;
        if (rate_ld_i) begin
            pend_d = rate_in_i;
        end else begin
            pend_d = pend_q;
        end
        if (clr_i || wrap_i) begin
            if (rate_ld_i) begin
                act_d = rate_in_i;
            end else if (rate_pend_i) begin
                act_d = pend_q;
            end else begin
                act_d = act_q;
            end
        end else begin
            act_d = act_q;
        end
        if (clr_i) begin
            pulse_d = 1'b0;
        end else if (en_i) begin
            pulse_d = sel_s | force_i;
        end else begin
            pulse_d = 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= {WIDTH{1'b0}};
            pend_q  <= {WIDTH{1'b0}};
            pulse_q <= 1'b0;
        end else begin
            act_q   <= act_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

`ifdef RATE_MULT_PULSE_CNT_EN
    localparam logic [WIDTH:0] ACC_MAX = {(WIDTH+1){1'b1}};

    logic [WIDTH:0] acc_q, acc_d;
    logic [WIDTH:0] pcnt_q, pcnt_d;
    logic [WIDTH:0] total_s;

    // Count pulses as they are registered so the wrap-edge pulse lands in the closing period.
    always_comb begin
        acc_d  = acc_q;
        pcnt_d = pcnt_q;
        if (pulse_d && (acc_q != ACC_MAX)) begin
            total_s = acc_q + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            total_s = acc_q;
        end
        if (clr_i) begin
            acc_d  = {(WIDTH+1){1'b0}};
            pcnt_d = pcnt_q;
        end else if (wrap_i) begin
            acc_d  = {(WIDTH+1){1'b0}};
            pcnt_d = total_s;
        end else begin
            acc_d  = total_s;
            pcnt_d = pcnt_q;
        end
    end

    // Accumulator and published per-period count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= {(WIDTH+1){1'b0}};
            pcnt_q <= {(WIDTH+1){1'b0}};
        end else begin
            acc_q  <= acc_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign pulse_cnt_o = pcnt_q;
`else
    assign pulse_cnt_o = {(WIDTH+1){1'b0}};
`endif

endmodule

// File: rtl/rate_mult_gen.sv
// Multi-channel binary rate multiplier sharing one free-running counter.
// Define RATE_MULT_PULSE_CNT_EN to publish per-channel pulse totals per period.
module rate_mult_gen
    import rate_mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic                        clr_i,
    input  logic [NUM_CH-1:0]           force_i,
    input  logic [NUM_CH*WIDTH-1:0]     rate_in_i,
    input  logic                        rate_ld_i,
    output logic                        rate_pend_o,
    output logic [WIDTH-1:0]            cnt_o,
    output logic                        tc_o,
    output logic [NUM_CH-1:0]           pulse_out_o,
    output logic [NUM_CH*(WIDTH+1)-1:0] pulse_cnt_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = CNT_ALL_ONES[WIDTH-1:0];

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             pend_q, pend_d;
    logic             wrap_s;

    assign wrap_s = en_i & ~clr_i & (cnt_q == CNT_MAX);

    // Counter, terminal count and pending flag next state.
    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        pend_d = pend_q;
        if (clr_i) begin
            cnt_d = {WIDTH{1'b0}};
            tc_d  = 1'b0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            tc_d  = (cnt_q == CNT_MAX);
        end else begin
            cnt_d = cnt_q;
            tc_d  = 1'b0;
        end
        if (clr_i || wrap_s) begin
            pend_d = 1'b0;
        end else if (rate_ld_i) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Shared state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= {WIDTH{1'b0}};
            tc_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            pend_q <= pend_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign tc_o        = tc_q;
    assign rate_pend_o = pend_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        rate_mult_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .en_i        (en_i),
            .clr_i       (clr_i),
            .force_i     (force_i[k]),
            .rate_in_i   (rate_in_i[k*WIDTH +: WIDTH]),
            .rate_ld_i   (rate_ld_i),
            .rate_pend_i (pend_q),
            .wrap_i      (wrap_s),
            .cnt_i       (cnt_q),
            .pulse_o     (pulse_out_o[k]),
            .pulse_cnt_o (pulse_cnt_o[k*(WIDTH+1) +: (WIDTH+1)])
        );
    end

endmodule

// File: tb/tb_rate_mult_gen.sv
// Directed self-checking bench for rate_mult_gen (WIDTH=8, NUM_CH=2).
// Pulse-count checks follow RATE_MULT_PULSE_CNT_EN when it is defined.
module tb_rate_mult_gen;

    localparam int W = 8;
    localparam int N = 2;

    logic             clk;
    logic             rst_n;
    logic             en_i;
    logic             clr_i;
    logic [N-1:0]     force_i;
    logic [N*W-1:0]   rate_in_i;
    logic             rate_ld_i;
    logic             rate_pend_o;
    logic [W-1:0]     cnt_o;
    logic             tc_o;
    logic [N-1:0]     pulse_out_o;
    logic [N*(W+1)-1:0] pulse_cnt_o;

    int n_checks;
    int n_err;
    int idx, n0, n1, ntc, tc_idx, first1, firstz1;

    rate_mult_gen #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .force_i     (force_i),
        .rate_in_i   (rate_in_i),
        .rate_ld_i   (rate_ld_i),
        .rate_pend_o (rate_pend_o),
        .cnt_o       (cnt_o),
        .tc_o        (tc_o),
        .pulse_out_o (pulse_out_o),
        .pulse_cnt_o (pulse_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        idx = 0; n0 = 0; n1 = 0; ntc = 0;
        tc_idx = -1; first1 = -1; firstz1 = -1;
    endtask

    // One clock edge, then tally what the outputs report for the pre-edge counter value.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pulse_out_o[0]) n0++;
        if (pulse_out_o[1]) begin
            n1++;
            if (first1 < 0) first1 = idx;
        end else if (firstz1 < 0) begin
            firstz1 = idx;
        end
        if (tc_o) begin
            ntc++;
            tc_idx = idx;
        end
        idx++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_clr(input logic [7:0] r0, input logic [7:0] r1);
        rate_in_i = {r1, r0};
        rate_ld_i = 1'b1;
        clr_i     = 1'b1;
        tick();
        rate_ld_i = 1'b0;
        clr_i     = 1'b0;
        clear_counts();
    endtask

    initial begin
        int bad;
        logic [W-1:0] frozen;
        n_checks = 0; n_err = 0;
        rst_n = 1'b0; en_i = 1'b0; clr_i = 1'b0; force_i = '0;
        rate_in_i = '0; rate_ld_i = 1'b0;
        clear_counts();
        #23;
        check_eq("rst_cnt", 32'(cnt_o), 32'd0);
        check_eq("rst_out", {29'd0, tc_o, pulse_out_o}, 32'd0);
        check_eq("rst_pend", 32'(rate_pend_o), 32'd0);
        check_eq("rst_pcnt", 32'(pulse_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full period with 0xA5 / 0x01.
        load_clr(8'hA5, 8'h01);
        check_eq("ld_clr_pend", 32'(rate_pend_o), 32'd0);
        en_i = 1'b1;
        run(256);
        check_eq("a5_count", 32'(n0), 32'd165);
        check_eq("r01_count", 32'(n1), 32'd1);
        check_eq("r01_slot", 32'(first1), 32'h80);
        check_eq("tc_count", 32'(ntc), 32'd1);
        check_eq("tc_slot", 32'(tc_idx), 32'hFF);
        check_eq("wrap_cnt", 32'(cnt_o), 32'd0);

        // Boundary rates 0x00 and 0xFF.
        load_clr(8'h00, 8'hFF);
        run(256);
        check_eq("r00_count", 32'(n0), 32'd0);
        check_eq("rff_count", 32'(n1), 32'd255);
        check_eq("rff_silent", 32'(firstz1), 32'd0);

        // Pending rate applied only at the wrap.
        load_clr(8'h80, 8'h00);
        run(64);
        rate_in_i = {8'h00, 8'h10};
        rate_ld_i = 1'b1;
        tick();
        rate_ld_i = 1'b0;
        check_eq("pend_set", 32'(rate_pend_o), 32'd1);
        run(190);
        check_eq("pend_pre_wrap_cnt", 32'(cnt_o), 32'hFF);
        check_eq("pend_pre_wrap", 32'(rate_pend_o), 32'd1);
        tick();
        check_eq("pend_clr_wrap", 32'(rate_pend_o), 32'd0);
        check_eq("old_rate_count", 32'(n0), 32'd128);
        clear_counts();
        run(256);
        check_eq("new_rate_count", 32'(n0), 32'd16);

        // Enable low mid-period with force held: counter frozen, no pulses.
        load_clr(8'hA5, 8'h01);
        run(100);
        frozen = cnt_o;
        en_i = 1'b0;
        force_i = 2'b11;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cnt_o !== frozen || pulse_out_o !== 2'b00 || tc_o !== 1'b0) bad++;
        end
        check_eq("en_low_frozen", 32'(bad), 32'd0);
        check_eq("en_low_cnt", 32'(frozen), 32'd100);
        en_i = 1'b1;
        force_i = 2'b00;
        run(156);
        check_eq("en_gap_a5", 32'(n0), 32'd165);
        check_eq("en_gap_01", 32'(n1), 32'd1);

        // clr at 0x37 with a rate pending: new rate active at once.
        load_clr(8'h80, 8'h00);
        run(48);
        rate_in_i = {8'h00, 8'h10};
        rate_ld_i = 1'b1;
        tick();
        rate_ld_i = 1'b0;
        run(6);
        check_eq("clr_pre_cnt", 32'(cnt_o), 32'h37);
        check_eq("clr_pre_pend", 32'(rate_pend_o), 32'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check_eq("clr_cnt", 32'(cnt_o), 32'd0);
        check_eq("clr_pend", 32'(rate_pend_o), 32'd0);
        check_eq("clr_out", {30'd0, pulse_out_o}, 32'd0);
        clear_counts();
        run(256);
        check_eq("clr_new_rate", 32'(n0), 32'd16);

        // Async reset mid-period discards pending rates.
        rate_in_i = {8'h33, 8'h22};
        rate_ld_i = 1'b1;
        tick();
        rate_ld_i = 1'b0;
        run(8);
        check_eq("pre_rst_pulse", 32'(pulse_out_o[0]), 32'd1);
        check_eq("pre_rst_pend", 32'(rate_pend_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_cnt", 32'(cnt_o), 32'd0);
        check_eq("async_out", {29'd0, tc_o, pulse_out_o}, 32'd0);
        check_eq("async_pend", 32'(rate_pend_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        run(256);
        check_eq("post_rst_ch0", 32'(n0), 32'd0);
        check_eq("post_rst_ch1", 32'(n1), 32'd0);
        check_eq("post_rst_pend", 32'(rate_pend_o), 32'd0);

        // Rate 0x03 plus two forced slots.
        load_clr(8'h03, 8'h00);
        run(16);
        force_i = 2'b01;
        run(2);
        force_i = 2'b00;
        run(238);
        check_eq("force_count", 32'(n0), 32'd5);
`ifdef RATE_MULT_PULSE_CNT_EN
        check_eq("pcnt_ch0", 32'(pulse_cnt_o[W:0]), 32'd5);
        check_eq("pcnt_ch1", 32'(pulse_cnt_o[2*W+1:W+1]), 32'd0);
`else
        check_eq("pcnt_off", 32'(pulse_cnt_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
